// File: rtl/oled_i2c_sequencer_pkg.sv
// Shared constants and types for the SSD1306 bring-up sequencer.
// Holds the control bytes, the I2C master state codes and the sequencer state enum.
package oled_i2c_sequencer_pkg;

  localparam logic [7:0] CTRL_CMD  = 8'h80;
  localparam logic [7:0] CTRL_DATA = 8'hC0;
  localparam logic [7:0] ROM_NOP   = 8'hE3;

  localparam logic [3:0] MST_IDLE  = 4'd0;
  localparam logic [3:0] MST_STOP  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CMD,
    S_DATA,
    S_DONE,
    S_ERR
  } seq_state_t;

endpackage

// File: rtl/oled_i2c_sequencer_if.sv
// Bus between the sequencer (master modport) and the I2C master engine (slave modport).
interface oled_i2c_sequencer_if;

  logic [3:0] m_state;
  logic [4:0] m_command_queue;
  logic [7:0] m_data_queue;
  logic       m_enable;
  logic [6:0] m_slave_addr;
  logic       m_read_write;
  logic [7:0] m_control_frame;
  logic [7:0] m_reg_addr;
  logic [7:0] m_data_write;

  modport master (
    input  m_state, m_command_queue, m_data_queue,
    output m_enable, m_slave_addr, m_read_write, m_control_frame, m_reg_addr, m_data_write
  );

  modport slave (
    output m_state, m_command_queue, m_data_queue,
    input  m_enable, m_slave_addr, m_read_write, m_control_frame, m_reg_addr, m_data_write
  );

endinterface

// File: rtl/oled_i2c_sequencer_init_rom.sv
// SSD1306 power-up command list; indices past the list return a NOP command.
module oled_init_rom
  import oled_i2c_sequencer_pkg::*;
(
  input  logic [4:0] i_idx,
  output logic [7:0] o_cmd
);

  always_comb begin
    case (i_idx)
      5'd0:  o_cmd = 8'hAE;
      5'd1:  o_cmd = 8'hD5;
      5'd2:  o_cmd = 8'h80;
      5'd3:  o_cmd = 8'hA8;
      5'd4:  o_cmd = 8'h3F;
      5'd5:  o_cmd = 8'hD3;
      5'd6:  o_cmd = 8'h00;
      5'd7:  o_cmd = 8'h40;
      5'd8:  o_cmd = 8'h8D;
      5'd9:  o_cmd = 8'h14;
      5'd10: o_cmd = 8'h20;
      5'd11: o_cmd = 8'h00;
      5'd12: o_cmd = 8'hA1;
      5'd13: o_cmd = 8'hC8;
      5'd14: o_cmd = 8'hDA;
      5'd15: o_cmd = 8'h12;
      5'd16: o_cmd = 8'h81;
      5'd17: o_cmd = 8'hCF;
      5'd18: o_cmd = 8'hD9;
      5'd19: o_cmd = 8'hF1;
      5'd20: o_cmd = 8'hDB;
      5'd21: o_cmd = 8'h40;
      5'd22: o_cmd = 8'hA4;
      5'd23: o_cmd = 8'hA6;
      5'd24: o_cmd = 8'hAF;
      5'd25: o_cmd = 8'h21;
      5'd26: o_cmd = 8'h00;
      5'd27: o_cmd = 8'h7F;
      5'd28: o_cmd = 8'h22;
      5'd29: o_cmd = 8'h00;
      5'd30: o_cmd = 8'h07;
      default: o_cmd = ROM_NOP;
    endcase
  end

endmodule

// File: rtl/oled_i2c_sequencer.sv
// Drives one I2C write transaction: SSD1306 init commands, then a GDDRAM clear.
// Progress is inferred from changes on the master's command/data queue counters.
module oled_i2c_sequencer
  import oled_i2c_sequencer_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h3C,
  parameter int          N_INIT      = 31,
  parameter int          FB_BYTES    = 1024,
  parameter logic [7:0]  FILL        = 8'h00,
  parameter logic [19:0] TIMEOUT_CYC = 20'hFFFFF
) (
  input  logic CLK,
  input  logic NRST,
  input  logic start,
  output logic busy,
  output logic done,
  output logic error,
  oled_i2c_sequencer_if.master bus
);

  localparam logic [4:0]  LAST_CMD  = 5'(N_INIT - 1);
  localparam logic [10:0] LAST_DATA = 11'(FB_BYTES - 1);

  seq_state_t  r_state, w_state_nxt;
  logic [4:0]  r_cmd_idx, w_cmd_idx_nxt;
  logic [10:0] r_data_cnt, w_data_cnt_nxt;
  logic [19:0] r_timer, w_timer_nxt;
  logic [4:0]  r_prev_cmdq;
  logic [7:0]  r_prev_dataq;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_error, w_error_nxt;
  logic        r_enable, w_enable_nxt;
  logic [7:0]  r_ctrl, w_ctrl_nxt;
  logic        w_cmd_consume, w_data_consume, w_abort, w_timeout, w_fail;
  logic [7:0]  w_rom_cmd;

  oled_init_rom u_rom (
    .i_idx (r_cmd_idx),
    .o_cmd (w_rom_cmd)
  );

  // Inequality rather than increment detection keeps counter wrap harmless.
  assign w_cmd_consume  = (bus.m_command_queue != r_prev_cmdq);
  assign w_data_consume = (bus.m_data_queue != r_prev_dataq);
  assign w_abort        = (bus.m_state == MST_STOP) || (bus.m_state == MST_IDLE);
  assign w_timeout      = (r_timer == TIMEOUT_CYC - 20'd1);

  always_comb begin
    // NOTE: every next value defaults to its current value first, so no branch can infer a latch.
    w_state_nxt    = r_state;
    w_cmd_idx_nxt  = r_cmd_idx;
    w_data_cnt_nxt = r_data_cnt;
    w_timer_nxt    = r_timer;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;
    w_enable_nxt   = r_enable;
    w_ctrl_nxt     = r_ctrl;
    w_fail         = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_state_nxt    = S_REQ;
          w_cmd_idx_nxt  = '0;
          w_data_cnt_nxt = '0;
          w_timer_nxt    = '0;
          w_ctrl_nxt     = CTRL_CMD;
          w_enable_nxt   = 1'b0;
          w_busy_nxt     = 1'b1;
          w_done_nxt     = 1'b0;
          w_error_nxt    = 1'b0;
        end
      end
      S_REQ: begin
        if (bus.m_state != MST_IDLE) begin
          w_state_nxt  = S_CMD;
          w_enable_nxt = 1'b1;
          w_timer_nxt  = '0;
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 20'd1;
        end
      end
      S_CMD: begin
        if (w_abort || w_timeout) begin
          w_fail = 1'b1;
        end else if (w_cmd_consume) begin
          w_timer_nxt   = '0;
          w_cmd_idx_nxt = r_cmd_idx + 5'd1;
          if (r_cmd_idx == LAST_CMD) begin
            w_ctrl_nxt  = CTRL_DATA;
            w_state_nxt = S_DATA;
          end
        end else begin
          w_timer_nxt = r_timer + 20'd1;
        end
      end
      S_DATA: begin
        if (w_abort || w_timeout) begin
          w_fail = 1'b1;
        end else if (w_data_consume) begin
          w_timer_nxt    = '0;
          w_data_cnt_nxt = r_data_cnt + 11'd1;
          if (r_data_cnt == LAST_DATA) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end
        end else begin
          w_timer_nxt = r_timer + 20'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort and timeout outrank a consume seen in the same cycle.
    if (w_fail) begin
      w_state_nxt  = S_ERR;
      w_error_nxt  = 1'b1;
      w_busy_nxt   = 1'b0;
      w_enable_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    r_prev_cmdq  <= bus.m_command_queue;
    r_prev_dataq <= bus.m_data_queue;
    if (!NRST) begin
      r_state    <= S_IDLE;
      r_cmd_idx  <= '0;
      r_data_cnt <= '0;
      r_timer    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_enable   <= 1'b1;
      r_ctrl     <= CTRL_CMD;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd_idx  <= w_cmd_idx_nxt;
      r_data_cnt <= w_data_cnt_nxt;
      r_timer    <= w_timer_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_enable   <= w_enable_nxt;
      r_ctrl     <= w_ctrl_nxt;
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign error               = r_error;
  assign bus.m_enable        = r_enable;
  assign bus.m_slave_addr    = SLAVE_ADDR;
  assign bus.m_read_write    = 1'b0;
  assign bus.m_control_frame = r_ctrl;
  assign bus.m_reg_addr      = w_rom_cmd;
  assign bus.m_data_write    = FILL;

endmodule

// File: tb/tb_oled_i2c_sequencer.sv
// Bench for oled_i2c_sequencer: a behavioural I2C master consumes bytes with random gaps
// while a byte-count reference model predicts command bytes, control mode and done/error.
module tb_oled_i2c_sequencer;
  import oled_i2c_sequencer_pkg::*;

  localparam int NCMD = 31;
  localparam int NFB  = 1024;
  localparam int TMO  = 100;
  localparam logic [7:0] ROM_REF [NCMD] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20,
    8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40,
    8'hA4, 8'hA6, 8'hAF, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };
  // {busy,done,error,enable,rw,slave_addr,ctrl,reg_addr,data_write} after reset
  localparam logic [35:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h3C, 8'h80, 8'hAE, 8'h00};

  logic CLK   = 1'b0;
  logic NRST  = 1'b0;
  logic start = 1'b0;
  logic busy, done, error;
  int   errors = 0;
  int   checks = 0;
  int   ref_cmds;
  int   ref_data;

  oled_i2c_sequencer_if bus ();

  oled_i2c_sequencer #(.TIMEOUT_CYC(20'(TMO))) dut (
    .CLK   (CLK),
    .NRST  (NRST),
    .start (start),
    .busy  (busy),
    .done  (done),
    .error (error),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  function automatic logic [35:0] out_vec();
    return {busy, done, error, bus.m_enable, bus.m_read_write, bus.m_slave_addr,
            bus.m_control_frame, bus.m_reg_addr, bus.m_data_write};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Master engine model: consume one byte after a random gap, in the mode the control frame selects.
  task automatic send_byte(output logic [7:0] ctrl, output logic [7:0] cmd);
    int gap;
    gap = int'($urandom_range(4, 1));
    for (int i = 0; i < gap; i++) tick();
    ctrl = bus.m_control_frame;
    cmd  = bus.m_reg_addr;
    if (ctrl == CTRL_CMD) bus.m_command_queue = bus.m_command_queue + 5'd1;
    else                  bus.m_data_queue    = bus.m_data_queue + 8'd1;
    tick();
  endtask

  task automatic launch(input string tag);
    int dly;
    bus.m_state         = 4'd0;
    bus.m_command_queue = 5'($urandom);
    bus.m_data_queue    = 8'($urandom);
    ref_cmds = 0;
    ref_data = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({busy, done, error, bus.m_enable} === 4'b1000,
          $sformatf("%s_start: busy/done/error/enable got %b want 1000", tag, {busy, done, error, bus.m_enable}));
    dly = int'($urandom_range(8, 1));
    for (int i = 0; i < dly; i++) begin
      tick();
      check(bus.m_enable === 1'b0, $sformatf("%s_req_hold: m_enable got %b want 0", tag, bus.m_enable));
    end
    bus.m_state = 4'd2;
    tick();
    check(bus.m_enable === 1'b1 && busy === 1'b1,
          $sformatf("%s_req_release: enable/busy got %b%b want 11", tag, bus.m_enable, busy));
  endtask

  task automatic run_cmds(input int n, input string tag);
    logic [7:0] c, r;
    for (int i = 0; i < n; i++) begin
      send_byte(c, r);
      check(c === CTRL_CMD && r === ROM_REF[ref_cmds],
            $sformatf("%s_cmd%0d: ctrl/cmd got %h/%h want %h/%h", tag, ref_cmds, c, r, CTRL_CMD, ROM_REF[ref_cmds]));
      ref_cmds++;
      check(bus.m_control_frame === ((ref_cmds >= NCMD) ? CTRL_DATA : CTRL_CMD),
            $sformatf("%s_mode%0d: ctrl got %h after %0d cmds", tag, ref_cmds, bus.m_control_frame, ref_cmds));
    end
  endtask

  task automatic run_data(input int n, input string tag);
    logic [7:0] c, r;
    for (int i = 0; i < n; i++) begin
      send_byte(c, r);
      ref_data++;
      check(c === CTRL_DATA && done === (ref_data >= NFB) && busy === (ref_data < NFB) && error === 1'b0,
            $sformatf("%s_data%0d: ctrl/done/busy/error got %h/%b/%b/%b want %h/%b/%b/0", tag, ref_data,
                      c, done, busy, error, CTRL_DATA, ref_data >= NFB, ref_data < NFB));
    end
  endtask

  task automatic test_reset();
    NRST = 1'b0;
    bus.m_state = 4'd0;
    bus.m_command_queue = 5'd0;
    bus.m_data_queue = 8'd0;
    tick();
    tick();
    check(out_vec() === RESET_VEC, $sformatf("reset_values: got %h want %h", out_vec(), RESET_VEC));
    NRST = 1'b1;
    tick();
    tick();
    check(out_vec() === RESET_VEC, $sformatf("reset_idle: got %h want %h", out_vec(), RESET_VEC));
  endtask

  task automatic test_full_sequence();
    launch("full");
    run_cmds(NCMD, "full");
    run_data(NFB, "full");
    run_data(3, "full_after");
  endtask

  task automatic test_nack();
    launch("nack");
    run_cmds(4, "nack");
    tick();
    bus.m_state = MST_STOP;
    tick();
    check({busy, done, error} === 3'b001,
          $sformatf("nack_error: busy/done/error got %b want 001", {busy, done, error}));
    bus.m_state = 4'd0;
    tick();
    check(error === 1'b1, $sformatf("nack_sticky: error got %b want 1", error));
    launch("nack_restart");
    check(error === 1'b0, $sformatf("nack_clear: error got %b want 0", error));
    run_cmds(NCMD, "nack_restart");
    run_data(NFB, "nack_restart");
  endtask

  task automatic test_timeout();
    launch("tmo");
    run_cmds(3, "tmo");
    for (int i = 0; i < TMO - 1; i++) tick();
    check(error === 1'b0 && busy === 1'b1,
          $sformatf("tmo_early: error/busy got %b%b want 01", error, busy));
    tick();
    check(error === 1'b1 && busy === 1'b0 && done === 1'b0,
          $sformatf("tmo_fire: error/busy/done got %b%b%b want 100", error, busy, done));
    bus.m_state = 4'd0;
  endtask

  task automatic test_reset_mid();
    launch("rmid");
    run_cmds(NCMD, "rmid");
    run_data(500, "rmid");
    NRST = 1'b0;
    bus.m_state = 4'd0;
    tick();
    check(out_vec() === RESET_VEC, $sformatf("rmid_reset: got %h want %h", out_vec(), RESET_VEC));
    NRST = 1'b1;
    tick();
    launch("rmid_restart");
    run_cmds(NCMD, "rmid_restart");
    run_data(NFB, "rmid_restart");
  endtask

  task automatic test_start_ignored();
    launch("ign");
    run_cmds(3, "ign");
    start = 1'b1;
    tick();
    start = 1'b0;
    check({busy, error, bus.m_enable} === 3'b101 && bus.m_control_frame === CTRL_CMD && bus.m_reg_addr === ROM_REF[3],
          $sformatf("ign_hold: busy/error/enable %b ctrl %h cmd %h want 101 %h %h",
                    {busy, error, bus.m_enable}, bus.m_control_frame, bus.m_reg_addr, CTRL_CMD, ROM_REF[3]));
    run_cmds(NCMD - 3, "ign");
    bus.m_state = 4'd0;
    tick();
    check({busy, done, error} === 3'b001,
          $sformatf("ign_abort_idle: busy/done/error got %b want 001", {busy, done, error}));
  endtask

  initial begin
    bus.m_state         = 4'd0;
    bus.m_command_queue = 5'd0;
    bus.m_data_queue    = 8'd0;
    test_reset();
    test_full_sequence();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
